// File: rtl/guess_match_if.sv
// Button/switch inputs and result/status outputs of the guess-match round controller.
interface guess_match_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             check;
  logic [WIDTH-1:0] guess;
  logic             match;
  logic             not_match;
  logic [WIDTH-1:0] target;
  logic [3:0]       tries_left;
  logic             round_active;

  modport master (
    output start, check, guess,
    input  match, not_match, target, tries_left, round_active
  );

  modport slave (
    input  start, check, guess,
    output match, not_match, target, tries_left, round_active
  );
endinterface

// File: rtl/guess_match_engine.sv
// Number-guessing round controller: free-running LFSR picks the secret on start,
// each check press compares the guess and holds a match/not_match result.
module guess_match_engine #(
  parameter int WIDTH       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         rst,
  guess_match_if.slave bus
);
  localparam int            TW         = $clog2(HOLD_CYCLES) + 1;
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {GEN, ARMED, OK, BAD} state_t;

  state_t           state, state_d;
  logic             start_q, check_q;
  logic             start_edge, check_edge;
  logic [7:0]       lfsr;
  logic [TW-1:0]    timer, timer_d;
  logic [WIDTH-1:0] target, target_d;
  logic [3:0]       tries, tries_d;
  logic             match_q, not_match_q, active_q;

  assign start_edge = bus.start & ~start_q;
  assign check_edge = bus.check & ~check_q;

  // x^8+x^6+x^5+x^4+1; a nonzero seed can never reach the all-zero lockup state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr    <= 8'hA5;
      start_q <= 1'b0;
      check_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      start_q <= bus.start;
      check_q <= bus.check;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= GEN;
      timer       <= '0;
      target      <= '0;
      tries       <= '0;
      match_q     <= 1'b0;
      not_match_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      target      <= target_d;
      tries       <= tries_d;
      match_q     <= (state_d == OK);
      not_match_q <= (state_d == BAD);
      active_q    <= (state_d == ARMED);
    end
  end

  always_comb begin
    state_d  = state;
    target_d = target;
    tries_d  = tries;
    timer_d  = (timer == '0) ? '0 : timer - TW'(1);
    case (state)
      GEN: begin
        if (start_edge) begin
          target_d = lfsr[WIDTH-1:0];
          tries_d  = TRIES_INIT;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        // start is ignored here, so a simultaneous start edge never reloads target
        if (check_edge) begin
          timer_d = HOLD_LOAD;
          if (bus.guess == target) begin
            state_d = OK;
          end else begin
            if (tries != 4'd0) tries_d = tries - 4'd1;
            state_d = BAD;
          end
        end
      end
      OK: begin
        if (timer == '0) state_d = GEN;
      end
      BAD: begin
        if (timer == '0) state_d = (tries != 4'd0) ? ARMED : GEN;
      end
      default: state_d = GEN;
    endcase
  end

  assign bus.match        = match_q;
  assign bus.not_match    = not_match_q;
  assign bus.target       = target;
  assign bus.tries_left   = tries;
  assign bus.round_active = active_q;
endmodule

// File: tb/tb_guess_match_engine.sv
// Scenario bench for guess_match_engine: expected results go into a scoreboard on each
// check press and are popped and compared once the held result has finished.
module tb_guess_match_engine;
  localparam int W  = 4;
  localparam int MT = 3;
  localparam int HC = 4;

  typedef struct {
    bit         is_match;
    logic [3:0] tries;
    bit         active_after;
  } exp_t;

  typedef struct {
    int           m_cnt;
    int           nm_cnt;
    bit           overlap;
    logic [3:0]   tries;
    bit           active_after;
    logic [W-1:0] tgt_after;
  } meas_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [7:0] m_lfsr;

  guess_match_if #(.WIDTH(W)) bus();

  guess_match_engine #(.WIDTH(W), .MAX_TRIES(MT), .HOLD_CYCLES(HC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference LFSR, used to predict the secret latched on a start edge
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Called at a negedge; returns at a negedge with start low for at least one edge
  task automatic do_start(output logic [W-1:0] t);
    bus.start = 1'b1;
    t = m_lfsr[W-1:0];
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // Pulses check for one edge and measures the result hold; optionally re-pokes check mid-hold
  task automatic press(input logic [W-1:0] g, input bit poke, output meas_t r);
    r.m_cnt = 0; r.nm_cnt = 0; r.overlap = 1'b0; r.tries = 4'hx;
    bus.guess = g;
    bus.check = 1'b1;
    @(negedge clk);
    bus.check = 1'b0;
    for (int i = 0; i < 20 && (bus.match || bus.not_match); i++) begin
      if (bus.match)                  r.m_cnt++;
      if (bus.not_match)              r.nm_cnt++;
      if (bus.match && bus.not_match) r.overlap = 1'b1;
      if (i == 0)                     r.tries = bus.tries_left;
      if (poke)                       bus.check = (i == 1);
      @(negedge clk);
    end
    bus.check      = 1'b0;
    r.active_after = bus.round_active;
    r.tgt_after    = bus.target;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    bus.check = 1'b0;
    bus.guess = '0;
    #3;
    n_asrt++;
    if ({bus.match, bus.not_match, bus.round_active} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {bus.match, bus.not_match, bus.round_active});
    end
    n_asrt++;
    if ({bus.target, bus.tries_left} !== 8'h00) begin
      n_fail++; $display("FAIL reset_regs got %h want 00", {bus.target, bus.tries_left});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start_hold();
    @(negedge clk);
    n_asrt++;
    if (bus.round_active !== 1'b1) begin
      n_fail++; $display("FAIL start_active got %b want 1", bus.round_active);
    end
    n_asrt++;
    if (bus.target !== 4'h5) begin
      n_fail++; $display("FAIL start_target got %h want 5", bus.target);
    end
    n_asrt++;
    if (bus.tries_left !== 4'd3) begin
      n_fail++; $display("FAIL start_tries got %0d want 3", bus.tries_left);
    end
    repeat (4) @(negedge clk);
    n_asrt++;
    if ({bus.round_active, bus.target, bus.tries_left} !== {1'b1, 4'h5, 4'd3}) begin
      n_fail++; $display("FAIL start_held got %b/%h/%0d want 1/5/3", bus.round_active, bus.target, bus.tries_left);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_match();
    meas_t r;
    exp_t  e;
    sb.push_back('{1'b1, 4'd3, 1'b0});
    press(4'h5, 1'b0, r);
    e = sb.pop_front();
    n_asrt++;
    if (r.m_cnt != HC || r.nm_cnt != 0) begin
      n_fail++; $display("FAIL match_len got m=%0d nm=%0d want m=%0d nm=0", r.m_cnt, r.nm_cnt, HC);
    end
    n_asrt++;
    if (r.tries !== e.tries || r.active_after !== e.active_after) begin
      n_fail++; $display("FAIL match_after got tries=%0d act=%b want %0d/%b", r.tries, r.active_after, e.tries, e.active_after);
    end
    n_asrt++;
    if (r.tgt_after !== 4'h5) begin
      n_fail++; $display("FAIL match_target got %h want 5", r.tgt_after);
    end
  endtask

  task automatic test_three_wrong();
    meas_t        r;
    exp_t         e;
    logic [W-1:0] t;
    do_start(t);
    n_asrt++;
    if (bus.target !== t) begin
      n_fail++; $display("FAIL wrong_target got %h want %h", bus.target, t);
    end
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{1'b0, 4'(2 - k), (k < 2)});
      press(t ^ 4'h1, 1'b0, r);
      e = sb.pop_front();
      n_asrt++;
      if (r.nm_cnt != HC || r.m_cnt != 0 || r.overlap) begin
        n_fail++; $display("FAIL wrong_len[%0d] got nm=%0d m=%0d ov=%b want nm=%0d m=0", k, r.nm_cnt, r.m_cnt, r.overlap, HC);
      end
      n_asrt++;
      if (r.tries !== e.tries || r.active_after !== e.active_after) begin
        n_fail++; $display("FAIL wrong_after[%0d] got tries=%0d act=%b want %0d/%b", k, r.tries, r.active_after, e.tries, e.active_after);
      end
    end
  endtask

  task automatic test_retry_ignore();
    meas_t        r;
    exp_t         e;
    logic [W-1:0] t;
    do_start(t);
    sb.push_back('{1'b0, 4'd2, 1'b1});
    press(t ^ 4'h2, 1'b1, r);
    e = sb.pop_front();
    n_asrt++;
    if (r.nm_cnt != HC || r.m_cnt != 0 || r.tries !== e.tries || r.active_after !== e.active_after) begin
      n_fail++; $display("FAIL retry_bad got nm=%0d m=%0d tries=%0d act=%b want %0d/0/%0d/%b", r.nm_cnt, r.m_cnt, r.tries, r.active_after, HC, e.tries, e.active_after);
    end
    sb.push_back('{1'b1, 4'd2, 1'b0});
    press(t, 1'b1, r);
    e = sb.pop_front();
    n_asrt++;
    if (r.m_cnt != HC || r.nm_cnt != 0 || r.tries !== e.tries || r.active_after !== e.active_after) begin
      n_fail++; $display("FAIL retry_ok got m=%0d nm=%0d tries=%0d act=%b want %0d/0/%0d/%b", r.m_cnt, r.nm_cnt, r.tries, r.active_after, HC, e.tries, e.active_after);
    end
  endtask

  task automatic test_start_check_same();
    meas_t        r;
    exp_t         e;
    logic [W-1:0] t;
    bit           any_high;
    do_start(t);
    bus.start = 1'b1;
    sb.push_back('{1'b0, 4'd2, 1'b1});
    press(t ^ 4'h4, 1'b0, r);
    bus.start = 1'b0;
    e = sb.pop_front();
    n_asrt++;
    if (r.nm_cnt != HC || r.tries !== e.tries || r.tgt_after !== t || r.active_after !== e.active_after) begin
      n_fail++; $display("FAIL same_edge got nm=%0d tries=%0d tgt=%h act=%b want %0d/%0d/%h/%b", r.nm_cnt, r.tries, r.tgt_after, r.active_after, HC, e.tries, t, e.active_after);
    end
    sb.push_back('{1'b1, 4'd2, 1'b0});
    press(t, 1'b0, r);
    e = sb.pop_front();
    n_asrt++;
    if (r.m_cnt != HC || r.active_after !== e.active_after) begin
      n_fail++; $display("FAIL same_finish got m=%0d act=%b want %0d/%b", r.m_cnt, r.active_after, HC, e.active_after);
    end
    bus.guess = t;
    bus.check = 1'b1;
    any_high  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.check = 1'b0;
      if (bus.match || bus.not_match || bus.round_active) any_high = 1'b1;
    end
    n_asrt++;
    if (any_high || bus.target !== t) begin
      n_fail++; $display("FAIL gen_check got high=%b tgt=%h want 0/%h", any_high, bus.target, t);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] t;
    do_start(t);
    bus.guess = t;
    bus.check = 1'b1;
    @(negedge clk);
    bus.check = 1'b0;
    @(negedge clk);
    n_asrt++;
    if (bus.match !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got match=%b want 1", bus.match);
    end
    #2 rst = 1'b0;
    #1;
    n_asrt++;
    if ({bus.match, bus.not_match, bus.round_active, bus.target, bus.tries_left} !== 11'd0) begin
      n_fail++; $display("FAIL mid_async got %b/%b/%b/%h/%0d want all 0", bus.match, bus.not_match, bus.round_active, bus.target, bus.tries_left);
    end
    @(negedge clk);
    rst = 1'b1;
    do_start(t);
    n_asrt++;
    if (bus.target !== 4'h5 || bus.round_active !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart got tgt=%h act=%b want 5/1", bus.target, bus.round_active);
    end
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_match();
    test_three_wrong();
    test_retry_ignore();
    test_start_check_same();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/guess_match_engine.md
# guess_match_engine

Round controller for the number-guessing game: runs an LFSR while idle, latches a secret target on `start`, compares the player's switch guess on each `check` press, and drives the `match` / `not_match` level pair consumed by the RGB LED controller. Also tracks remaining attempts. It sits between the board buttons/switches and the LED and display logic.

## Interface

- `WIDTH`, 4: guess/target width, legal range 1..8.
- `MAX_TRIES`, 3: attempts per round, legal range 1..15.
- `HOLD_CYCLES`, 50_000_000: cycles a result stays asserted, must be ≥1.

- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: start button, already synchronized/debounced; acts on rising edge.
- `check`, input, 1: check button, already synchronized/debounced; acts on rising edge.
- `guess`, input, WIDTH: player guess, sampled on the `check` edge cycle.
- `match`, output, 1: guess equals target (result display).
- `not_match`, output, 1: guess differs from target (result display).
- `target`, output, WIDTH: latched secret, for debug/reveal display.
- `tries_left`, output, 4: remaining attempts in the current round.
- `round_active`, output, 1: high while the round is waiting for guesses (ARMED).

## Operation

- Edge detect: a registered copy of each of `start` and `check`, reset to 0. Edge = input 1 and previous 0 in the same cycle. Edges are never queued; any edge not consumed in its cycle is lost.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, reset seed 8'hA5. It advances every cycle in all states and never reaches zero.
- States:
  - GEN (reset state): `match`=`not_match`=0, so the LED shows blue. A `start` edge latches `target` ← lfsr[WIDTH-1:0] and `tries_left` ← MAX_TRIES, then goes to ARMED. `check` is ignored.
  - ARMED: `round_active`=1. On a `check` edge, compare `guess` to `target`:
    - Equal: go to OK.
    - Unequal: `tries_left` decrements by 1, then go to BAD.
    - `start` is ignored. If `start` and `check` edges arrive in the same cycle, `check` wins.
  - OK: `match`=1. The timer counts HOLD_CYCLES cycles, then the block goes to GEN.
  - BAD: `not_match`=1. After HOLD_CYCLES cycles, go to ARMED if `tries_left`≠0, else go to GEN.
  - All edges are ignored in OK and BAD.
- `match` and `not_match` are never high together. Both are registered and decoded directly from the state register.
- `target` holds its value until the next `start` in GEN, including across the return to GEN.
- `tries_left` is never decremented below 0. It is 4 bits wide and zero-extended from the MAX_TRIES value.
- Timer: down-counter of width clog2(HOLD_CYCLES)+1. It loads HOLD_CYCLES-1 on entry to OK or BAD and leaves the state on the cycle it reads 0.

## Timing

- Reset values: state GEN, `match`=0, `not_match`=0, `target`=0, `tries_left`=0, `round_active`=0, lfsr=8'hA5, edge registers 0.
- Reset assertion clears everything immediately, asynchronously, from any state, including mid-hold. Release is synchronous to `clk`.
- Start latency: if `start` rises before edge N, then `round_active`=1 and `target` is valid after edge N.
- Check latency: if `check` rises before edge N, then `match` or `not_match` is high after edge N. It stays high for exactly HOLD_CYCLES cycles. It is low after edge N+HOLD_CYCLES, when the next state also takes effect.
- Back-to-back: a `check` edge arriving on the first ARMED cycle after BAD is accepted.

## Test plan

- Reset, then hold `start` high from the first cycle → exactly one round starts; `target`=lfsr[3:0] of the sampling cycle; `tries_left`=3; `round_active`=1 one cycle later; holding `start` high does not restart.
- HOLD_CYCLES=4, `guess`=`target`, pulse `check` → `match`=1 for exactly 4 cycles with `not_match`=0 → GEN, `round_active`=0, `target` unchanged.
- MAX_TRIES=3, three wrong guesses → `not_match` pulses 3 times, each 4 cycles; `tries_left` goes 2, 1, 0; after the third pulse the block is in GEN, not ARMED.
- Wrong guess, then correct guess on the second try → `tries_left`=2 and a `match` pulse. Also pulse `check` during OK/BAD → ignored, no extra result.
- `start` and `check` edges in the same ARMED cycle → compare occurs, `target` is not reloaded. `check` in GEN → no output change.
- Assert `rst` low in the middle of a `match` hold → `match`=0 immediately, with no clock needed; after release, the block is in GEN and lfsr=8'hA5.
